jtpopeye_rom_arb: RTL and testbench

//  Parametrised SDRAM read arbiter; next generation of the fixed two-port (main/obj) ROM

---
 rtl/jtpopeye_rom_arb_pkg.sv | 15 +
 rtl/jtpopeye_rom_slot.sv | 45 ++++
 rtl/jtpopeye_rom_arb.sv | 145 ++++++++++++++
 tb/tb_jtpopeye_rom_arb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtpopeye_rom_arb_pkg.sv
// Shared definitions for the ROM read arbiter.
//   st_e    : arbiter FSM encoding (ST_IDLE, ST_WAIT)
//   DEF_AW  : default SDRAM word address width
//   DEF_DW  : default SDRAM data width
package jtpopeye_rom_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,   // no read outstanding, looking for a miss to serve
        ST_WAIT = 1'b1    // one read outstanding, waiting for sdram_rdy
    } st_e;

    localparam int DEF_AW = 22;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/jtpopeye_rom_slot.sv
// One-word read cache entry for a single arbiter channel.
//   clk, rst  : clock, synchronous active-high reset (clears valid, tag, data)
//   flush     : drop the cached word (valid <= 0); tag and data are kept
//   fill      : load {fill_addr, fill_data} and mark the entry valid
//   addr      : channel's current word address, compared against the tag
//   hit       : entry valid and tag equals addr
//   data      : cached word, always visible regardless of hit
module jtpopeye_rom_slot
    import jtpopeye_rom_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [DW-1:0] data
);

    logic          valid;
    logic [AW-1:0] tag;

    // Flush outranks fill so a download can never leave a stale word valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            data  <= fill_data;
        end
    end

    assign hit = valid && (tag == addr);

endmodule

// File: rtl/jtpopeye_rom_arb.sv
// SDRAM read arbiter with a one-word cache per channel.
//   clk, rst     : 20 MHz clock, synchronous active-high reset
//   downloading  : ROM download in progress; FSM forced idle, caches flushed
//   ch_cs        : per-channel read request (level)
//   ch_addr      : per-channel word address, channel k at [k*AW +: AW]
//   ch_dout      : per-channel cached word, channel k at [k*DW +: DW]
//   ch_ok        : ch_dout is valid for the channel's current address
//   sdram_re     : request strobe, each edge (either direction) is one read
//   sdram_addr   : address of the outstanding read, stable while waiting
//   sdram_rdy    : one-cycle pulse, data_read holds the requested word
//   data_read    : SDRAM read data
//   state        : current FSM state (observation only)
//
// Request handshake: a read is issued by toggling sdram_re with sdram_addr
// already set; the controller answers with a single sdram_rdy pulse. Only one
// read is outstanding at a time. If no answer arrives within TIMEOUT+1 cycles
// the same read is re-issued with another toggle. A sdram_rdy pulse while no
// read is outstanding carries no meaning and is ignored.
module jtpopeye_rom_arb
    import jtpopeye_rom_arb_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter bit PRIO0    = 1'b1,
    parameter int TIMEOUT  = 63
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   downloading,
    input  logic [CHANNELS-1:0]    ch_cs,
    input  logic [CHANNELS*AW-1:0] ch_addr,
    output logic [CHANNELS*DW-1:0] ch_dout,
    output logic [CHANNELS-1:0]    ch_ok,
    output logic                   sdram_re,
    output logic [AW-1:0]          sdram_addr,
    input  logic                   sdram_rdy,
    input  logic [DW-1:0]          data_read,
    output st_e                    state
);

    localparam int GW = $clog2(CHANNELS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);

    logic [AW-1:0]       addr_a [CHANNELS];
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] need;
    logic [CHANNELS-1:0] fill;
    logic [GW-1:0]       gsel;
    logic [GW-1:0]       rr;
    logic [GW-1:0]       gnt;
    logic                gnt_ok;
    logic                gnt_rr;   // grant came from the round-robin search
    logic [TW-1:0]       timer;
    int                  idx;

    // A fill is only honoured while a read is outstanding; downloading masks it.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        assign addr_a[k] = ch_addr[k*AW +: AW];
        assign fill[k]   = (state == ST_WAIT) && sdram_rdy && !downloading
                           && (gsel == GW'(k));

        jtpopeye_rom_slot #(
            .AW (AW),
            .DW (DW)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flush     (downloading),
            .fill      (fill[k]),
            .fill_addr (sdram_addr),
            .fill_data (data_read),
            .addr      (addr_a[k]),
            .hit       (hit[k]),
            .data      (ch_dout[k*DW +: DW])
        );

        assign ch_ok[k] = ch_cs[k] & hit[k];
    end

    assign need = ch_cs & ~hit;

    // Arbitration: ch0 may have absolute priority; otherwise search starts one
    // past the last round-robin winner and wraps, so the nearest miss wins.
    always_comb begin
        gnt_ok = 1'b0;
        gnt_rr = 1'b0;
        gnt    = '0;
        idx    = 0;
        if (PRIO0 && need[0]) begin
            gnt_ok = 1'b1;
        end else begin
            for (int i = 1; i <= CHANNELS; i++) begin
                idx = (int'(rr) + i) % CHANNELS;
                if (!gnt_ok && need[idx]) begin
                    gnt_ok = 1'b1;
                    gnt_rr = 1'b1;
                    gnt    = GW'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sdram_re   <= 1'b0;
            sdram_addr <= '0;
            gsel       <= '0;
            rr         <= '0;
            timer      <= '0;
        end else if (downloading) begin
            // Any outstanding read is abandoned; sdram_re keeps its level so
            // no spurious request edge is produced.
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_ok) begin
                        sdram_addr <= addr_a[gnt];
                        gsel       <= gnt;
                        sdram_re   <= ~sdram_re;
                        timer      <= TMO_LOAD;
                        state      <= ST_WAIT;
                        if (gnt_rr) rr <= gnt;
                    end
                end
                ST_WAIT: begin
                    // A reply on the expiry cycle still completes the read.
                    if (sdram_rdy) begin
                        state <= ST_IDLE;
                    end else if (timer == '0) begin
                        sdram_re <= ~sdram_re;
                        timer    <= TMO_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtpopeye_rom_arb.sv
// Randomised bench for jtpopeye_rom_arb. Two instances share the channel
// inputs: u_prio (PRIO0=1) and u_rr (PRIO0=0). Each has its own SDRAM
// responder. A transaction-level model per instance predicts every output
// on every cycle.
module tb_jtpopeye_rom_arb;
    import jtpopeye_rom_arb_pkg::*;

    localparam int CH   = 4;
    localparam int AW   = 22;
    localparam int DW   = 32;
    localparam int TMO  = 6;
    localparam int NCYC = 4000;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             downloading;
    logic [CH-1:0]    ch_cs;
    logic [CH*AW-1:0] ch_addr;
    logic [CH*DW-1:0] ch_dout    [2];
    logic [CH-1:0]    ch_ok      [2];
    logic             sdram_re   [2];
    logic [AW-1:0]    sdram_addr [2];
    logic             sdram_rdy  [2];
    logic [DW-1:0]    data_read  [2];
    st_e              state      [2];

    jtpopeye_rom_arb #(.CHANNELS(CH), .AW(AW), .DW(DW), .PRIO0(1'b1), .TIMEOUT(TMO)) u_prio (
        .clk(clk), .rst(rst), .downloading(downloading), .ch_cs(ch_cs), .ch_addr(ch_addr),
        .ch_dout(ch_dout[0]), .ch_ok(ch_ok[0]), .sdram_re(sdram_re[0]),
        .sdram_addr(sdram_addr[0]), .sdram_rdy(sdram_rdy[0]), .data_read(data_read[0]),
        .state(state[0])
    );

    jtpopeye_rom_arb #(.CHANNELS(CH), .AW(AW), .DW(DW), .PRIO0(1'b0), .TIMEOUT(TMO)) u_rr (
        .clk(clk), .rst(rst), .downloading(downloading), .ch_cs(ch_cs), .ch_addr(ch_addr),
        .ch_dout(ch_dout[1]), .ch_ok(ch_ok[1]), .sdram_re(sdram_re[1]),
        .sdram_addr(sdram_addr[1]), .sdram_rdy(sdram_rdy[1]), .data_read(data_read[1]),
        .state(state[1])
    );

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Cache contents, whether a read is outstanding, which channel it serves,
    // its address, the strobe level, cycles spent waiting, last rr winner.
    logic          m_valid [2][CH];
    logic [AW-1:0] m_tag   [2][CH];
    logic [DW-1:0] m_data  [2][CH];
    bit            m_busy  [2];
    int            m_g     [2];
    logic [AW-1:0] m_lat   [2];
    logic          m_re    [2];
    int            m_waited[2];
    int            m_rr    [2];

    function automatic logic [AW-1:0] get_addr(input int k);
        return ch_addr[k*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return DW'(32'h9E37_79B9 * {10'd0, a}) ^ 32'h0BAD_F00D;
    endfunction

    function automatic bit m_hit(input int p, input int k);
        return m_valid[p][k] && (m_tag[p][k] == get_addr(k));
    endfunction

    task automatic model_reset(input int p);
        for (int k = 0; k < CH; k++) begin
            m_valid[p][k] = 1'b0;
            m_tag[p][k]   = '0;
            m_data[p][k]  = '0;
        end
        m_busy[p] = 0; m_g[p] = 0; m_lat[p] = '0; m_re[p] = 1'b0;
        m_waited[p] = 0; m_rr[p] = 0;
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step(input int p);
        bit found;
        int g;
        if (rst) begin
            model_reset(p);
            return;
        end
        if (downloading) begin
            m_busy[p] = 0;
            for (int k = 0; k < CH; k++) m_valid[p][k] = 1'b0;
            return;
        end
        if (!m_busy[p]) begin
            found = 0;
            g = 0;
            if (p == 0 && ch_cs[0] && !m_hit(p, 0)) begin
                found = 1;
            end else begin
                for (int off = 1; off <= CH; off++) begin
                    int c;
                    c = (m_rr[p] + off) % CH;
                    if (!found && ch_cs[c] && !m_hit(p, c)) begin
                        found = 1;
                        g = c;
                    end
                end
                if (found) m_rr[p] = g;
            end
            if (found) begin
                m_lat[p] = get_addr(g);
                m_g[p] = g;
                m_re[p] = ~m_re[p];
                m_waited[p] = 0;
                m_busy[p] = 1;
            end
        end else if (sdram_rdy[p]) begin
            m_valid[p][m_g[p]] = 1'b1;
            m_tag[p][m_g[p]]   = m_lat[p];
            m_data[p][m_g[p]]  = data_read[p];
            m_busy[p] = 0;
        end else begin
            m_waited[p]++;
            if (m_waited[p] == TMO + 1) begin
                m_re[p] = ~m_re[p];
                m_waited[p] = 0;
            end
        end
    endtask

    task automatic compare_all(input int p);
        check($sformatf("p%0d sdram_re", p), 64'(sdram_re[p]), 64'(m_re[p]));
        check($sformatf("p%0d sdram_addr", p), 64'(sdram_addr[p]), 64'(m_lat[p]));
        check($sformatf("p%0d state_wait", p), 64'(state[p] == ST_WAIT), 64'(m_busy[p]));
        for (int k = 0; k < CH; k++) begin
            check($sformatf("p%0d ch_ok[%0d]", p, k), 64'(ch_ok[p][k]),
                  64'(ch_cs[k] && m_hit(p, k)));
            check($sformatf("p%0d ch_dout[%0d]", p, k), 64'(ch_dout[p][k*DW +: DW]),
                  64'(m_data[p][k]));
        end
    endtask

    // ---------------- SDRAM responder ----------------
    logic          last_re[2];
    bit            pend   [2];
    int            cnt    [2];
    logic [AW-1:0] paddr  [2];

    task automatic respond(input int p);
        if (sdram_re[p] !== last_re[p]) begin
            // A new edge replaces any earlier request (timeout re-issue).
            last_re[p] = sdram_re[p];
            pend[p] = 1;
            cnt[p] = $urandom_range(1, TMO + 3);
            paddr[p] = sdram_addr[p];
        end
        sdram_rdy[p] = 1'b0;
        if (pend[p]) begin
            if (cnt[p] <= 1) begin
                sdram_rdy[p] = 1'b1;
                data_read[p] = mem_word(paddr[p]);
                pend[p] = 0;
            end else begin
                cnt[p]--;
            end
        end else if ($urandom_range(0, 59) == 0) begin
            sdram_rdy[p] = 1'b1;   // stray pulse with junk data
            data_read[p] = $urandom;
        end
    endtask

    // ---------------- driver ----------------
    int dl_left = 0;

    task automatic drive_inputs();
        rst = ($urandom_range(0, 499) == 0);
        if (dl_left > 0) begin
            downloading = 1'b1;
            dl_left--;
        end else if ($urandom_range(0, 199) == 0) begin
            downloading = 1'b1;
            dl_left = $urandom_range(2, 8);
        end else begin
            downloading = 1'b0;
        end
        for (int k = 0; k < CH; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                ch_cs[k] = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 9) == 0)
                    ch_addr[k*AW +: AW] = AW'($urandom);
                else
                    ch_addr[k*AW +: AW] = AW'($urandom_range(0, 11));
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        downloading = 1'b0;
        ch_cs = '0;
        ch_addr = '0;
        for (int p = 0; p < 2; p++) begin
            sdram_rdy[p] = 1'b0;
            data_read[p] = '0;
            last_re[p] = 1'b0;
            pend[p] = 0;
            cnt[p] = 0;
            paddr[p] = '0;
            model_reset(p);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            check($sformatf("p%0d reset sdram_re", p), 64'(sdram_re[p]), 64'd0);
            check($sformatf("p%0d reset sdram_addr", p), 64'(sdram_addr[p]), 64'd0);
            check($sformatf("p%0d reset ch_ok", p), 64'(ch_ok[p]), 64'd0);
            check($sformatf("p%0d reset ch_dout", p), 64'(ch_dout[p][63:0]), 64'd0);
            check($sformatf("p%0d reset state", p), 64'(state[p]), 64'(ST_IDLE));
        end

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            compare_all(0);
            compare_all(1);
            respond(0);
            respond(1);
            drive_inputs();
            if (rst) begin
                for (int p = 0; p < 2; p++) begin
                    pend[p] = 0;
                    last_re[p] = 1'b0;
                end
            end
            model_step(0);
            model_step(1);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
